int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//  Interrupt sequencer for the 5-stage pipeline core. Samples the active-low OINT_n[2:0]
//  request lines and picks the highest-priority one. Drains and flushes the pipeline,
//  saves the return PC and redirects IF to a vector. Drives the IACK_n acknowledge to
//  the external controller. On eret it restores the PC.
//  Sits beside the hazard unit. Its outputs feed the IF PC-select and the IF/ID and ID/EX
//  flush inputs.
// PARAMETERS
//  VEC_BASE    32'h0000_0080  address of the level-0 vector
//  VEC_STRIDE  8              byte distance between level vectors
//  ACK_CYCLES  2              cycles IACK_n is held low (1..15)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous reset, active-high
//  OINT_n         in   3   interrupt requests, active-low level; bit 2 = highest priority
//  IACK_n         out  1   interrupt acknowledge, active-low
//  pipe_stall     in   1   hazard/memory-wait stall in progress (IF/ID write disabled)
//  ex_pc          in   32  PC of the instruction currently in EX (the return address)
//  eret           in   1   return-from-interrupt decoded in ID (1-cycle pulse)
//  flush          out  1   squash IF/ID and ID/EX contents
//  pc_redirect    out  1   IF loads redirect_addr next edge
//  redirect_addr  out  32  vector or return address
//  epc            out  32  saved return PC
//  cur_level      out  2   level in service (0..2), valid while busy
//  busy           out  1   handler active (interrupts masked)
// BEHAVIOUR
//  - Reset: state=IDLE; IACK_n=1; flush=0; pc_redirect=0; redirect_addr=0; epc=0;
//    cur_level=0; busy=0; synchronizer flops=3'b111. Reset is honoured in any state;
//    IACK_n rises within the reset assertion.
//  - Synchroniser: OINT_n passes through 2 flops. A request reaches the FSM 2 cycles after
//    the pin falls. req = ~sync. Priority: bit2 > bit1 > bit0. Level = index of the winner.
//  - States:
//    IDLE     : if |req and !busy -> latch level and go DRAIN.
//    DRAIN    : wait while pipe_stall=1. When pipe_stall=0: epc<=ex_pc, flush=1 for
//               this one cycle, then go VECTOR.
//    VECTOR   : pc_redirect=1 for 1 cycle; redirect_addr = VEC_BASE + level*VEC_STRIDE
//               (32-bit, wraps mod 2^32); busy<=1; go ACK.
//    ACK      : IACK_n=0 for exactly ACK_CYCLES cycles (4-bit counter); then go SERVICE.
//    SERVICE  : wait for eret. On eret: pc_redirect=1 and flush=1 for 1 cycle,
//               redirect_addr=epc, busy<=0, then go IDLE.
//  - Latency: pin fall to pc_redirect is at least 5 cycles (2 sync + IDLE + DRAIN + VECTOR),
//    plus any pipe_stall cycles.
//  - Request drop: if the request disappears while in DRAIN, the sequence still completes
//    with the latched level. There is no spurious cancel.
//  - eret outside SERVICE is ignored (no redirect).
//  - eret and a pending request in the same cycle: eret wins. The request is taken from
//    IDLE on the next cycle.
//  - Level-triggered: a line still low after eret re-enters the handler.
//  - flush and pc_redirect are registered outputs, never asserted together except on the
//    eret cycle.
// CONFIGURATION
//  INT_NEST_EN defined:
//   - In SERVICE, a req of strictly higher level than cur_level preempts the handler.
//   - {epc,cur_level} is pushed into a 1-deep shadow and the DRAIN..ACK sequence runs again.
//   - The first eret restores from the shadow into SERVICE at the old level.
//   - Nesting depth is 1: while nested, further requests wait.
//  INT_NEST_EN undefined: all requests are masked while busy=1. The shadow logic is absent.
// TESTING
//  1 OINT_n=3'b110, no stall -> pc_redirect 5 cycles after the pin fall,
//    redirect_addr=32'h80, IACK_n low 2 cycles, busy=1.
//  2 OINT_n=3'b010 (lines 0 and 2 requesting) -> cur_level=2, redirect_addr=32'h90.
//  3 pipe_stall=1 for 4 cycles while in DRAIN -> flush delayed 4 cycles;
//    epc = ex_pc sampled on the release cycle.
//  4 In SERVICE with epc=32'h0000_1234, pulse eret -> redirect_addr=32'h1234, flush=1,
//    busy=0 on the next cycle.
//  5 Assert rst during ACK -> IACK_n=1 and state IDLE at once; no redirect after the
//    reset is released.
//  6 (INT_NEST_EN) level 0 in service, line 2 falls -> vector 32'h90. Two erets return
//    first to the level-0 handler, then to the original PC.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt sequencer: syncs OINT_n, drains/flushes the pipe, vectors IF, handshakes IACK_n, restores PC on eret.
// Optional nesting of one strictly-higher level behind macro INT_NEST_EN (default build: masked while busy).
module int_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
    parameter int          VEC_STRIDE = 8,
    parameter int          ACK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  OINT_n,
    output logic        IACK_n,
    input  logic        pipe_stall,
    input  logic [31:0] ex_pc,
    input  logic        eret,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic [31:0] epc,
    output logic [1:0]  cur_level,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_VECTOR,
        S_ACK,
        S_SERVICE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [3:0]  r_ack_cnt;
    logic [2:0]  w_req;
    logic        w_any;
    logic [1:0]  w_lvl;

`ifdef INT_NEST_EN
    logic        r_nested;
    logic [31:0] r_sh_epc;
    logic [1:0]  r_sh_lvl;
    logic        w_preempt;
`endif

    always_comb begin
        w_req = ~r_sync2;
        w_any = |w_req;
        if (w_req[2])      w_lvl = 2'd2;
        else if (w_req[1]) w_lvl = 2'd1;
        else               w_lvl = 2'd0;
`ifdef INT_NEST_EN
        w_preempt = !r_nested && w_any && (w_lvl > cur_level);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1       <= 3'b111;
            r_sync2       <= 3'b111;
            r_state       <= S_IDLE;
            r_ack_cnt     <= 4'd0;
            IACK_n        <= 1'b1;
            flush         <= 1'b0;
            pc_redirect   <= 1'b0;
            redirect_addr <= 32'd0;
            epc           <= 32'd0;
            cur_level     <= 2'd0;
            busy          <= 1'b0;
`ifdef INT_NEST_EN
            r_nested      <= 1'b0;
            r_sh_epc      <= 32'd0;
            r_sh_lvl      <= 2'd0;
`endif
        end else begin
            r_sync1     <= OINT_n;
            r_sync2     <= r_sync1;
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any && !busy) begin
                        cur_level <= w_lvl;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!pipe_stall) begin
                        epc     <= ex_pc;
                        flush   <= 1'b1;
                        r_state <= S_VECTOR;
                    end
                end
                S_VECTOR: begin
                    pc_redirect   <= 1'b1;
                    redirect_addr <= VEC_BASE + 32'(cur_level) * 32'(VEC_STRIDE);
                    busy          <= 1'b1;
                    IACK_n        <= 1'b0;
                    r_ack_cnt     <= 4'(ACK_CYCLES - 1);
                    r_state       <= S_ACK;
                end
                S_ACK: begin
                    // IACK_n went low on entry, so the count covers exactly ACK_CYCLES cycles
                    if (r_ack_cnt == 4'd0) begin
                        IACK_n  <= 1'b1;
                        r_state <= S_SERVICE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt - 4'd1;
                    end
                end
                S_SERVICE: begin
                    if (eret) begin
                        pc_redirect   <= 1'b1;
                        flush         <= 1'b1;
                        redirect_addr <= epc;
`ifdef INT_NEST_EN
                        if (r_nested) begin
                            epc       <= r_sh_epc;
                            cur_level <= r_sh_lvl;
                            r_nested  <= 1'b0;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_preempt) begin
                        r_sh_epc  <= epc;
                        r_sh_lvl  <= cur_level;
                        r_nested  <= 1'b1;
                        cur_level <= w_lvl;
                        r_state   <= S_DRAIN;
                    end
`else
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: vectoring, priority, stall drain, eret, reset in ACK, retrigger (+nesting if enabled).
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  OINT_n;
    logic        IACK_n;
    logic        pipe_stall;
    logic [31:0] ex_pc;
    logic        eret;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic [31:0] epc;
    logic [1:0]  cur_level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int_ctrl dut (
        .clk(clk), .rst(rst), .OINT_n(OINT_n), .IACK_n(IACK_n), .pipe_stall(pipe_stall),
        .ex_pc(ex_pc), .eret(eret), .flush(flush), .pc_redirect(pc_redirect),
        .redirect_addr(redirect_addr), .epc(epc), .cur_level(cur_level), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_eret;
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; OINT_n = 3'b111; pipe_stall = 1'b0; ex_pc = 32'd0; eret = 1'b0;
        tick(); tick();
        checks++; if (IACK_n !== 1'b1) begin errors++; $display("FAIL reset_iack: got %b want 1", IACK_n); end
        checks++; if ({flush, pc_redirect, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b want 000", {flush, pc_redirect, busy}); end
        checks++; if (redirect_addr !== 32'd0 || epc !== 32'd0 || cur_level !== 2'd0) begin errors++; $display("FAIL reset_regs: got addr %h epc %h lvl %0d want 0/0/0", redirect_addr, epc, cur_level); end
        rst = 1'b0;
        tick();
    endtask

    // Level 0, no stall: redirect 5 edges after the pin fall, IACK low 2 cycles.
    task automatic test_single;
        int early;
        early = 0;
        ex_pc = 32'h0000_1234;
        OINT_n = 3'b110;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (pc_redirect !== 1'b0) early++;
            if (i == 3) begin
                checks++; if (flush !== 1'b0) begin errors++; $display("FAIL single_flush_early: got %b want 0", flush); end
            end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL single_latency: redirect seen %0d cycles early want 0", early); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL single_flush: got %b want 1", flush); end
        checks++; if (epc !== 32'h0000_1234) begin errors++; $display("FAIL single_epc: got %h want 00001234", epc); end
        tick();
        checks++; if (pc_redirect !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL single_redirect: got redir %b flush %b want 1 0", pc_redirect, flush); end
        checks++; if (redirect_addr !== 32'h0000_0080) begin errors++; $display("FAIL single_vec: got %h want 00000080", redirect_addr); end
        checks++; if (busy !== 1'b1 || cur_level !== 2'd0) begin errors++; $display("FAIL single_busy: got busy %b lvl %0d want 1 0", busy, cur_level); end
        checks++; if (IACK_n !== 1'b0) begin errors++; $display("FAIL single_ack1: got %b want 0", IACK_n); end
        OINT_n = 3'b111;
        tick();
        checks++; if (IACK_n !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL single_ack2: got iack %b redir %b want 0 0", IACK_n, pc_redirect); end
        tick();
        checks++; if (IACK_n !== 1'b1) begin errors++; $display("FAIL single_ack_end: got %b want 1", IACK_n); end
    endtask

    // Runs from SERVICE with epc=1234 left by test_single.
    task automatic test_eret;
        do_eret();
        checks++; if (pc_redirect !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL eret_ctl: got redir %b flush %b want 1 1", pc_redirect, flush); end
        checks++; if (redirect_addr !== 32'h0000_1234) begin errors++; $display("FAIL eret_addr: got %h want 00001234", redirect_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eret_busy: got %b want 0", busy); end
        tick();
        checks++; if (pc_redirect !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL eret_pulse: got redir %b flush %b want 0 0", pc_redirect, flush); end
    endtask

    task automatic test_eret_ignored;
        do_eret();
        checks++; if (pc_redirect !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL eret_idle: got redir %b flush %b busy %b want 000", pc_redirect, flush, busy); end
        tick();
    endtask

    task automatic test_priority;
        ex_pc = 32'h0000_4000;
        OINT_n = 3'b010;
        repeat (5) tick();
        checks++; if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0000_0090) begin errors++; $display("FAIL prio_vec: got redir %b addr %h want 1 00000090", pc_redirect, redirect_addr); end
        checks++; if (cur_level !== 2'd2) begin errors++; $display("FAIL prio_level: got %0d want 2", cur_level); end
        OINT_n = 3'b111;
        repeat (2) tick();
        do_eret();
        checks++; if (redirect_addr !== 32'h0000_4000) begin errors++; $display("FAIL prio_ret: got %h want 00004000", redirect_addr); end
        tick();
    endtask

    task automatic test_stall;
        int bad;
        bad = 0;
        ex_pc = 32'hAAAA_0000;
        OINT_n = 3'b101;
        repeat (3) tick();
        pipe_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (flush !== 1'b0 || pc_redirect !== 1'b0) bad++;
            ex_pc = ex_pc + 32'h10;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: flush/redirect seen %0d times want 0", bad); end
        pipe_stall = 1'b0;
        ex_pc = 32'h0000_2468;
        tick();
        checks++; if (flush !== 1'b1 || epc !== 32'h0000_2468) begin errors++; $display("FAIL stall_release: got flush %b epc %h want 1 00002468", flush, epc); end
        tick();
        checks++; if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0000_0088) begin errors++; $display("FAIL stall_vec: got redir %b addr %h want 1 00000088", pc_redirect, redirect_addr); end
        OINT_n = 3'b111;
        repeat (2) tick();
        do_eret();
        tick();
    endtask

    task automatic test_reset_in_ack;
        int bad;
        bad = 0;
        OINT_n = 3'b110;
        repeat (5) tick();
        checks++; if (IACK_n !== 1'b0) begin errors++; $display("FAIL rst_ack_pre: got %b want 0", IACK_n); end
        OINT_n = 3'b111;
        rst = 1'b1;
        #1;
        checks++; if (IACK_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_ack_async: got iack %b busy %b want 1 0", IACK_n, busy); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pc_redirect !== 1'b0 || IACK_n !== 1'b1 || flush !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_ack_quiet: activity seen %0d cycles want 0", bad); end
    endtask

    // Line held low across eret: eret wins, then the request re-enters from IDLE.
    task automatic test_retrigger;
        ex_pc = 32'h0000_5000;
        OINT_n = 3'b011;
        repeat (7) tick();
        ex_pc = 32'h0000_6000;
        do_eret();
        checks++; if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0000_5000) begin errors++; $display("FAIL retrig_eret: got redir %b addr %h want 1 00005000", pc_redirect, redirect_addr); end
        tick();
        checks++; if (flush !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL retrig_gap: got flush %b redir %b want 0 0", flush, pc_redirect); end
        tick();
        checks++; if (flush !== 1'b1 || epc !== 32'h0000_6000) begin errors++; $display("FAIL retrig_flush: got flush %b epc %h want 1 00006000", flush, epc); end
        tick();
        checks++; if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0000_0090) begin errors++; $display("FAIL retrig_vec: got redir %b addr %h want 1 00000090", pc_redirect, redirect_addr); end
        OINT_n = 3'b111;
        repeat (2) tick();
        do_eret();
        tick();
    endtask

`ifdef INT_NEST_EN
    task automatic test_nest;
        ex_pc = 32'h0000_1000;
        OINT_n = 3'b110;
        repeat (5) tick();
        OINT_n = 3'b111;
        repeat (4) tick();
        ex_pc = 32'h0000_2000;
        OINT_n = 3'b011;
        repeat (5) tick();
        checks++; if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0000_0090 || cur_level !== 2'd2) begin errors++; $display("FAIL nest_vec: got redir %b addr %h lvl %0d want 1 00000090 2", pc_redirect, redirect_addr, cur_level); end
        OINT_n = 3'b111;
        repeat (2) tick();
        do_eret();
        checks++; if (redirect_addr !== 32'h0000_2000 || busy !== 1'b1 || cur_level !== 2'd0) begin errors++; $display("FAIL nest_ret1: got addr %h busy %b lvl %0d want 00002000 1 0", redirect_addr, busy, cur_level); end
        tick();
        do_eret();
        checks++; if (redirect_addr !== 32'h0000_1000 || busy !== 1'b0) begin errors++; $display("FAIL nest_ret2: got addr %h busy %b want 00001000 0", redirect_addr, busy); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_eret();
        test_eret_ignored();
        test_priority();
        test_stall();
        test_reset_in_ack();
        test_retrigger();
`ifdef INT_NEST_EN
        test_nest();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
